// File: rtl/caesar_pkg.sv
// rtl/caesar_pkg.sv - shared Caesar alphabet constants and symbol/key types
package caesar_pkg;

  localparam int ALPHA = 26;
  localparam int KEY_W = 5;
  localparam int SYM_W = 6;

  typedef logic [SYM_W-1:0] caesar_sym_t;
  typedef logic [KEY_W-1:0] caesar_key_t;

endpackage

// File: rtl/caesar_prescaler.sv
// rtl/caesar_prescaler.sv - free-running divide-by-DIV counter with a one-cycle tick
module caesar_prescaler #(
  parameter int DIV = 8
) (
  input  logic CLOCK_50,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/caesar_stimulus_gen.sv
// rtl/caesar_stimulus_gen.sv - plaintext/key/mode triple generator; CAESAR_TICK_SIM_EN forces DIV=8
module caesar_stimulus_gen #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1,
  parameter int ALPHA   = caesar_pkg::ALPHA,
  parameter int KEY_W   = caesar_pkg::KEY_W
) (
  input  logic                     CLOCK_50,
  input  logic                     rst,
  input  logic [KEY_W-1:0]         sw_key,
  input  logic                     sw_encrypt,
  input  logic                     pause,
  input  logic                     step,
  output caesar_pkg::caesar_sym_t  plain_value,
  output logic [KEY_W-1:0]         key_value,
  output logic                     encrypt_mode,
  output logic                     plain_upd,
  output logic                     key_err,
  output logic                     tick
);

  import caesar_pkg::*;

`ifdef CAESAR_TICK_SIM_EN
  localparam int DIV = 8;
`else
  localparam int DIV = CLK_HZ / TICK_HZ;
`endif

  localparam caesar_sym_t SYM_LAST  = caesar_sym_t'(ALPHA - 1);
  localparam caesar_sym_t SYM_ALPHA = caesar_sym_t'(ALPHA);

  logic [KEY_W-1:0] key_meta, key_sync;
  logic             enc_meta, enc_sync;
  logic             pause_meta, pause_sync;
  logic             step_meta, step_sync, step_sync_d;
  logic             step_rise, adv, key_ok;
  caesar_sym_t      key_ext;

  caesar_prescaler #(.DIV(DIV)) u_prescaler (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .tick     (tick)
  );

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      key_meta    <= '0;
      key_sync    <= '0;
      enc_meta    <= 1'b0;
      enc_sync    <= 1'b0;
      pause_meta  <= 1'b0;
      pause_sync  <= 1'b0;
      step_meta   <= 1'b0;
      step_sync   <= 1'b0;
      step_sync_d <= 1'b0;
    end else begin
      key_meta    <= sw_key;
      key_sync    <= key_meta;
      enc_meta    <= sw_encrypt;
      enc_sync    <= enc_meta;
      pause_meta  <= pause;
      pause_sync  <= pause_meta;
      step_meta   <= step;
      step_sync   <= step_meta;
      step_sync_d <= step_sync;
    end
  end

  // Paused: only step advances. Running: only the prescaler tick advances.
  assign step_rise = step_sync & ~step_sync_d;
  assign adv       = (tick & ~pause_sync) | (step_rise & pause_sync);
  assign key_ext   = caesar_sym_t'(key_sync);
  assign key_ok    = (key_ext < SYM_ALPHA);

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      plain_value  <= '0;
      key_value    <= '0;
      encrypt_mode <= 1'b1;
      plain_upd    <= 1'b0;
      key_err      <= 1'b0;
    end else begin
      plain_upd <= adv;
      if (adv) begin
        plain_value  <= (plain_value == SYM_LAST) ? '0 : plain_value + 1'b1;
        encrypt_mode <= enc_sync;
        key_err      <= ~key_ok;
        if (key_ok) begin
          key_value <= key_sync;
        end
      end
    end
  end

endmodule

// File: tb/tb_caesar_stimulus_gen.sv
// tb/tb_caesar_stimulus_gen.sv - directed self-checking bench for caesar_stimulus_gen (DIV=8)
module tb_caesar_stimulus_gen;

  logic       CLOCK_50 = 1'b0;
  logic       rst;
  logic [4:0] sw_key;
  logic       sw_encrypt;
  logic       pause;
  logic       step;
  logic [5:0] plain_value;
  logic [4:0] key_value;
  logic       encrypt_mode;
  logic       plain_upd;
  logic       key_err;
  logic       tick;

  int passed = 0;
  int total  = 0;
  int exp_plain;

  // CLK_HZ/TICK_HZ = 8 gives DIV = 8 with or without the simulation macro.
  caesar_stimulus_gen #(
    .CLK_HZ  (8),
    .TICK_HZ (1),
    .ALPHA   (26),
    .KEY_W   (5)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .rst          (rst),
    .sw_key       (sw_key),
    .sw_encrypt   (sw_encrypt),
    .pause        (pause),
    .step         (step),
    .plain_value  (plain_value),
    .key_value    (key_value),
    .encrypt_mode (encrypt_mode),
    .plain_upd    (plain_upd),
    .key_err      (key_err),
    .tick         (tick)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLOCK_50);
      n++;
      if (tick) break;
    end
    chk("tick_seen", int'(tick), 1);
  endtask

  task automatic cycles(input int k, output int ups, output int tks);
    ups = 0;
    tks = 0;
    for (int j = 0; j < k; j++) begin
      @(negedge CLOCK_50);
      ups += int'(plain_upd);
      tks += int'(tick);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_plain"}, int'(plain_value), 0);
    chk({tag, "_key"},   int'(key_value), 0);
    chk({tag, "_mode"},  int'(encrypt_mode), 1);
    chk({tag, "_upd"},   int'(plain_upd), 0);
    chk({tag, "_err"},   int'(key_err), 0);
    chk({tag, "_tick"},  int'(tick), 0);
  endtask

  initial begin
    int n, ups, tks, u2, t2;

    rst = 1'b1; pause = 1'b0; step = 1'b0; sw_key = 5'd3; sw_encrypt = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    chk_reset("rst0");
    rst = 1'b0;
    exp_plain = 0;

    // 27 ticks: 1..25, 0, 1; update one cycle after each tick
    for (int i = 1; i <= 27; i++) begin
      wait_tick(n);
      chk("t1_interval", n, 7);
      chk("t1_upd_at_tick", int'(plain_upd), 0);
      @(negedge CLOCK_50);
      exp_plain = (exp_plain == 25) ? 0 : exp_plain + 1;
      chk("t1_upd", int'(plain_upd), 1);
      chk("t1_plain", int'(plain_value), exp_plain);
      chk("t1_key", int'(key_value), 3);
      chk("t1_mode", int'(encrypt_mode), 1);
    end
    chk("t1_wrap_end", int'(plain_value), 1);

    // key change mid-interval is held until the next advance
    repeat (3) @(negedge CLOCK_50);
    sw_key = 5'd7;
    wait_tick(n);
    chk("t2_interval", n, 4);
    chk("t2_key_held", int'(key_value), 3);
    @(negedge CLOCK_50);
    exp_plain++;
    chk("t2_upd", int'(plain_upd), 1);
    chk("t2_plain", int'(plain_value), exp_plain);
    chk("t2_key", int'(key_value), 7);
    chk("t2_err", int'(key_err), 0);

    // illegal key holds the old key and flags an error; legal 25 clears it
    sw_key = 5'd28;
    wait_tick(n);
    chk("t3_interval", n, 7);
    @(negedge CLOCK_50);
    exp_plain++;
    chk("t3_plain", int'(plain_value), exp_plain);
    chk("t3_key_hold", int'(key_value), 7);
    chk("t3_err", int'(key_err), 1);
    sw_key = 5'd25;
    sw_encrypt = 1'b0;
    wait_tick(n);
    @(negedge CLOCK_50);
    exp_plain++;
    chk("t3_plain2", int'(plain_value), exp_plain);
    chk("t3_key25", int'(key_value), 25);
    chk("t3_err_clr", int'(key_err), 0);
    chk("t3_mode", int'(encrypt_mode), 0);

    // paused: frozen for 40 cycles while tick keeps running
    pause = 1'b1;
    cycles(40, ups, tks);
    chk("t4_ticks", tks, 5);
    chk("t4_ups", ups, 0);
    chk("t4_frozen", int'(plain_value), exp_plain);
    ups = 0;
    for (int p = 0; p < 2; p++) begin
      step = 1'b1;
      cycles(2, u2, t2);
      ups += u2;
      step = 1'b0;
      cycles(3, u2, t2);
      ups += u2;
    end
    exp_plain += 2;
    chk("t4_step_ups", ups, 2);
    chk("t4_step_plain", int'(plain_value), exp_plain);

    // paused step rising in the same cycle as a tick: one advance
    wait_tick(n);
    repeat (6) @(negedge CLOCK_50);
    step = 1'b1;
    cycles(2, ups, tks);
    chk("t5_align_tick", int'(tick), 1);
    step = 1'b0;
    cycles(4, u2, t2);
    ups += u2;
    exp_plain++;
    chk("t5_align_ups", ups, 1);
    chk("t5_align_plain", int'(plain_value), exp_plain);

    // unpause keeps prescaler phase; step is ignored while running
    pause = 1'b0;
    wait_tick(n);
    chk("t5_unpause_phase", n, 4);
    @(negedge CLOCK_50);
    exp_plain++;
    chk("t5_run_upd", int'(plain_upd), 1);
    chk("t5_run_plain", int'(plain_value), exp_plain);
    step = 1'b1;
    cycles(2, ups, tks);
    step = 1'b0;
    cycles(3, u2, t2);
    chk("t5_step_ignored", ups + u2, 0);
    chk("t5_no_tick", tks + t2, 0);
    chk("t5_plain_same", int'(plain_value), exp_plain);

    // run to 17, then reset mid-count
    while (exp_plain < 17) begin
      wait_tick(n);
      @(negedge CLOCK_50);
      exp_plain++;
      chk("t6_plain", int'(plain_value), exp_plain);
    end
    repeat (3) @(negedge CLOCK_50);
    rst = 1'b1;
    @(negedge CLOCK_50);
    chk_reset("rst1");
    rst = 1'b0;
    wait_tick(n);
    chk("t6_first_tick", n, 7);
    @(negedge CLOCK_50);
    chk("t6_upd", int'(plain_upd), 1);
    chk("t6_plain1", int'(plain_value), 1);
    chk("t6_key", int'(key_value), 25);
    chk("t6_mode", int'(encrypt_mode), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
